// File: rtl/crc_frame_sched_if.sv
// Stream bundle between the two frame sources, the CRC scheduler and the link transmitter.
interface crc_frame_sched_if #(parameter int N = 16);
  logic         req0_valid, req0_last, req0_ready;
  logic [N-1:0] req0_data;
  logic         req1_valid, req1_last, req1_ready;
  logic [N-1:0] req1_data;
  logic         out_valid, out_last, out_src, out_ready, busy;
  logic [N-1:0] out_data;

  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_last, out_src, busy
  );

  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_last, out_src, busy
  );
endinterface

// File: rtl/crc_frame_sched.sv
// Round-robin two-source frame scheduler sharing one CRC-16 word engine.
// Payload passes straight through; the CRC is appended as a trailer beat.
module crc_frame_sched #(
  parameter int           N    = 16,
  parameter logic [N-1:0] POLY = 16'h1021,
  parameter logic [N-1:0] INIT = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Rst,
  crc_frame_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

  state_t       state;
  logic [N-1:0] crc;
  logic         gnt, pri;
  logic         g_valid, g_last;
  logic [N-1:0] g_data;

  // MSB-first bit-serial update unrolled into a single cycle.
  function automatic logic [N-1:0] crc_word(input logic [N-1:0] c, input logic [N-1:0] d);
    logic [N-1:0] r;
    logic         fb;
    r = c;
    for (int k = N - 1; k >= 0; k--) begin
      fb = r[N-1] ^ d[k];
      r  = {r[N-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  always_comb begin
    g_valid        = gnt ? bus.req1_valid : bus.req0_valid;
    g_data         = gnt ? bus.req1_data  : bus.req0_data;
    g_last         = gnt ? bus.req1_last  : bus.req0_last;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;
    bus.out_last   = 1'b0;
    bus.out_src    = 1'b0;
    case (state)
      DATA: begin
        bus.out_valid = g_valid;
        bus.out_data  = g_data;
        bus.out_src   = gnt;
        if (gnt) bus.req1_ready = bus.out_ready;
        else     bus.req0_ready = bus.out_ready;
      end
      CRC: begin
        bus.out_valid = 1'b1;
        bus.out_data  = crc;
        bus.out_last  = 1'b1;
        bus.out_src   = gnt;
      end
      default: ;
    endcase
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      crc   <= INIT;
      gnt   <= 1'b0;
      pri   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req0_valid || bus.req1_valid) begin
          // pri only breaks ties; a lone requester always wins.
          gnt   <= (bus.req0_valid && bus.req1_valid) ? pri : bus.req1_valid;
          crc   <= INIT;
          state <= DATA;
        end
        DATA: if (g_valid && bus.out_ready) begin
          crc <= crc_word(crc, g_data);
          if (g_last) state <= CRC;
        end
        CRC: if (bus.out_ready) begin
          pri   <= ~gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
